// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encoding and frame constants shared by the loader files.
package imem_loader_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream in, instruction memory write port out.
interface imem_loader_if #(parameter int ADDR_WIDTH = 6);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    modport master (output byte_valid, byte_data, input byte_ready, mem_we, mem_addr, mem_wdata);
    modport slave  (input byte_valid, byte_data, output byte_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader_timeout.sv
// loader_timeout: counts enabled cycles since the last clear and flags when the limit is hit.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt;
    assign expired = enable && !clear && cnt == W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (reset || clear) cnt <= '0;
        else if (enable)    cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed LE byte stream into 32-bit words and
// writes them to consecutive instruction memory addresses while holding the CPU.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 6,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    imem_loader_if.slave        bus,
    output logic                cpu_hold,
    output logic                done,
    output logic                error,
    output logic [15:0]         words_loaded
);
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);
    state_t state, state_n;
    logic [15:0] count;
    logic [15:0] hdr_count;
    logic [1:0] idx;
    logic [31:0] word;
    logic [ADDR_WIDTH-1:0] addr;
    logic ready, xfer, go, tmo, last_word;
    assign ready = state inside {S_HDR_LO, S_HDR_HI, S_DATA};
    assign xfer = ready && bus.byte_valid;
    assign go = start && state inside {S_IDLE, S_DONE, S_ERROR};
    assign hdr_count = {bus.byte_data, count[7:0]};
    assign last_word = words_loaded + 16'd1 == count;
    assign bus.byte_ready = ready;
    assign bus.mem_we = state == S_WRITE;
    assign bus.mem_addr = addr;
    assign bus.mem_wdata = word;
    assign cpu_hold = ready || state == S_WRITE;
    assign done = state == S_DONE;
    assign error = state == S_ERROR;
    loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (go || xfer),
        .enable (ready),
        .expired(tmo)
    );
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: state_n = start ? S_HDR_LO : state;
            S_HDR_LO: state_n = tmo ? S_ERROR : xfer ? S_HDR_HI : state;
            S_HDR_HI: state_n = tmo ? S_ERROR : !xfer ? state :
                                hdr_count == 16'd0 ? S_DONE :
                                {1'b0, hdr_count} > DEPTH ? S_ERROR : S_DATA;
            S_DATA: state_n = tmo ? S_ERROR :
                              (xfer && idx == 2'(BYTES_PER_WORD - 1)) ? S_WRITE : state;
            S_WRITE: state_n = last_word ? S_DONE : S_DATA;
            default: state_n = S_IDLE;
        endcase
    end
    // Bytes shift in from the top so the first byte ends up in word[7:0].
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            count <= '0;
            idx <= '0;
            word <= '0;
            addr <= '0;
            words_loaded <= '0;
        end else begin
            state <= state_n;
            if (go) begin
                words_loaded <= '0;
                addr <= '0;
                idx <= '0;
            end
            if (xfer && state == S_HDR_LO) count[7:0] <= bus.byte_data;
            if (xfer && state == S_HDR_HI) begin
                count[15:8] <= bus.byte_data;
                idx <= '0;
            end
            if (xfer && state == S_DATA) begin
                word <= {bus.byte_data, word[31:8]};
                idx <= idx + 2'd1;
            end
            if (state == S_WRITE) begin
                addr <= addr + ADDR_WIDTH'(1);
                words_loaded <= words_loaded + 16'd1;
            end
        end
    end
endmodule
